// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard unit (writeback source, forward select, FSM states).
// Revision 1.0
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    WB_PC4  = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_MW_ALU  = 2'd1,
    FWD_MW_LOAD = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;

  localparam int unsigned WAIT_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_cmp.sv
// hazard_fwd_cmp: dependency check and forward-select for one Execute source operand.
// Revision 1.0
`default_nettype none

module hazard_fwd_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] rs_E,
  input  logic       rs_en_E,
  input  logic [4:0] rd_MW,
  input  logic       reg_wrMW,
  input  logic [1:0] wb_selMW,
  output fwd_sel_e   fwd_sel
);

  logic dep;

  // x0 is hard-wired zero, so a write to it never creates a dependency
  assign dep = rs_en_E & reg_wrMW & (rd_MW != 5'd0) & (rs_E == rd_MW);

  always_comb begin
    fwd_sel = FWD_RF;
    if (dep) begin
      fwd_sel = (wb_sel_e'(wb_selMW) == WB_LOAD) ? FWD_MW_LOAD : FWD_MW_ALU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the 3-stage core with a bounded memory-wait FSM.
// Revision 1.0 -- optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic             rs1_en_E,
  input  logic             rs2_en_E,
  input  logic [4:0]       rd_MW,
  input  logic             reg_wrMW,
  input  logic [1:0]       wb_selMW,
  input  logic             mem_req_MW,
  input  logic             dmem_rsp_valid,
  input  logic             br_taken_E,
  output logic             stall_FE,
  output logic             Stall_MW,
  output logic             flush_FE,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(TIMEOUT_CYC);

  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255) || (CNT_W < 1)) begin : g_param_check
    $error("hazard_unit: TIMEOUT_CYC must be 1..255 and CNT_W >= 1");
  end

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  terr_q, terr_d;
  logic                  stall;
  fwd_sel_e              fwd_a, fwd_b;

  hazard_fwd_cmp u_fwd_a (
    .rs_E     (rs1_E),
    .rs_en_E  (rs1_en_E),
    .rd_MW    (rd_MW),
    .reg_wrMW (reg_wrMW),
    .wb_selMW (wb_selMW),
    .fwd_sel  (fwd_a)
  );

  hazard_fwd_cmp u_fwd_b (
    .rs_E     (rs2_E),
    .rs_en_E  (rs2_en_E),
    .rd_MW    (rd_MW),
    .reg_wrMW (reg_wrMW),
    .wb_selMW (wb_selMW),
    .fwd_sel  (fwd_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req_MW && !dmem_rsp_valid) begin
          stall   = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A response arriving on the timeout cycle still releases the pipeline
        if (dmem_rsp_valid) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          if (cnt_q == TIMEOUT_LIM) begin
            state_d = ERR;
            terr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
          end
        end
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign stall_FE    = stall;
  assign Stall_MW    = stall;
  // A held branch re-presents after the stall, so it is flushed then
  assign flush_FE    = br_taken_E & ~stall;
  assign fwd_sel_a   = fwd_a;
  assign fwd_sel_b   = fwd_b;
  assign timeout_err = terr_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_MW) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_FE) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
